fib_seq_param: RTL and testbench

FIB_SEQ_PARAM -- requirements
Module: fib_seq_param

---
 rtl/fib_seq_pkg.sv | 50 +++++
 rtl/fib_seq_param_step.sv | 32 +++
 rtl/fib_seq_param.sv | 163 ++++++++++++++++
 tb/tb_fib_seq_param.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fib_seq_pkg.sv
// Shared types and seed constants for the parameterised integer-sequence generator.
package fib_seq_pkg;

  // Recurrence selector; encoding matches the 2-bit mode input.
  typedef enum logic [1:0] {
    FIB   = 2'b00,
    LUCAS = 2'b01,
    TRIB  = 2'b10,
    PELL  = 2'b11
  } mode_e;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // Seed terms per recurrence. Tribonacci is the only one with a third seed.
  localparam int SEED_FIB_T0   = 0;
  localparam int SEED_FIB_T1   = 1;
  localparam int SEED_LUCAS_T0 = 2;
  localparam int SEED_LUCAS_T1 = 1;
  localparam int SEED_TRIB_T0  = 0;
  localparam int SEED_TRIB_T1  = 0;
  localparam int SEED_TRIB_T2  = 1;
  localparam int SEED_PELL_T0  = 0;
  localparam int SEED_PELL_T1  = 1;

  // First term of the selected sequence.
  function automatic int seed_t0(input mode_e m);
    case (m)
      LUCAS:   seed_t0 = SEED_LUCAS_T0;
      TRIB:    seed_t0 = SEED_TRIB_T0;
      PELL:    seed_t0 = SEED_PELL_T0;
      default: seed_t0 = SEED_FIB_T0;
    endcase
  endfunction

  // Second term of the selected sequence.
  function automatic int seed_t1(input mode_e m);
    case (m)
      LUCAS:   seed_t1 = SEED_LUCAS_T1;
      TRIB:    seed_t1 = SEED_TRIB_T1;
      PELL:    seed_t1 = SEED_PELL_T1;
      default: seed_t1 = SEED_FIB_T1;
    endcase
  endfunction

endpackage

// File: rtl/fib_seq_param_step.sv
// Combinational recurrence step: next term and carry-out from three history terms.
module fib_step
  import fib_seq_pkg::*;
#(
  parameter int WIDTH = 11
) (
  input  logic [WIDTH-1:0] i_t0,    // T(k-1)
  input  logic [WIDTH-1:0] i_t1,    // T(k-2)
  input  logic [WIDTH-1:0] i_t2,    // T(k-3)
  input  mode_e            i_mode,
  output logic [WIDTH-1:0] o_next,
  output logic             o_carry
);

  // Two guard bits hold the worst case (three-term add or 2*a+b).
  logic [WIDTH+1:0] w_full;

  // Evaluate the selected recurrence at full precision.
  always_comb begin
    w_full = '0;
    case (i_mode)
      FIB, LUCAS: w_full = {2'b00, i_t0} + {2'b00, i_t1};
      TRIB:       w_full = {2'b00, i_t0} + {2'b00, i_t1} + {2'b00, i_t2};
      PELL:       w_full = {1'b0, i_t0, 1'b0} + {2'b00, i_t1};
      default:    w_full = '0;
    endcase
  end

  assign o_next  = w_full[WIDTH-1:0];
  assign o_carry = |w_full[WIDTH+1:WIDTH];

endmodule

// File: rtl/fib_seq_param.sv
// Sequence generator: Fibonacci/Lucas/Tribonacci/Pell terms with running sum,
// one term per enabled cycle, stopping at index LIMIT.
//
// Handshake: start is honoured only in IDLE or DONE and wins over selector there;
// in RUN, selector=1 advances exactly one term on that edge and selector=0 holds
// every register. rst is synchronous and overrides everything.
module fib_seq_param
  import fib_seq_pkg::*;
#(
  parameter int WIDTH = 11,
  parameter int LIMIT = 23
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             selector,
  output logic [WIDTH-1:0] i,
  output logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] sum,
  output logic             done,
  output logic             overflow,
  output state_e           o_dbg_state
);

  // Registered state; r_t0 is the current term, r_t1/r_t2 the two before it.
  state_e           r_state;
  mode_e            r_mode;
  logic [WIDTH-1:0] r_i;
  logic [WIDTH-1:0] r_t0;
  logic [WIDTH-1:0] r_t1;
  logic [WIDTH-1:0] r_t2;
  logic [WIDTH-1:0] r_sum;
  logic             r_done;
  logic             r_ov;

  // Next-state values.
  state_e           w_state;
  mode_e            w_mode;
  logic [WIDTH-1:0] w_i;
  logic [WIDTH-1:0] w_t0;
  logic [WIDTH-1:0] w_t1;
  logic [WIDTH-1:0] w_t2;
  logic [WIDTH-1:0] w_sum;
  logic             w_done;
  logic             w_ov;

  // Term datapath.
  mode_e            w_start_mode;
  logic [WIDTH-1:0] w_step_next;
  logic             w_step_carry;
  logic [WIDTH-1:0] w_term;
  logic             w_term_carry;
  logic [WIDTH:0]   w_sum_add;
  logic             w_last;

  assign w_start_mode = mode_e'(mode);

  fib_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_t0    (r_t0),
    .i_t1    (r_t1),
    .i_t2    (r_t2),
    .i_mode  (r_mode),
    .o_next  (w_step_next),
    .o_carry (w_step_carry)
  );

  // Early indices come from the seed table; only real recurrence adds can carry.
  always_comb begin
    w_term       = w_step_next;
    w_term_carry = w_step_carry;
    if (r_i == '0) begin
      w_term       = WIDTH'(seed_t1(r_mode));
      w_term_carry = 1'b0;
    end else if (r_mode == TRIB && r_i == WIDTH'(1)) begin
      w_term       = WIDTH'(SEED_TRIB_T2);
      w_term_carry = 1'b0;
    end
  end

  assign w_sum_add = {1'b0, r_sum} + {1'b0, w_term};
  assign w_last    = (r_i == WIDTH'(LIMIT - 1));

  // Next-state and next-register logic.
  always_comb begin
    w_state = r_state;
    w_mode  = r_mode;
    w_i     = r_i;
    w_t0    = r_t0;
    w_t1    = r_t1;
    w_t2    = r_t2;
    w_sum   = r_sum;
    w_done  = r_done;
    w_ov    = r_ov;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_state = RUN;
          w_mode  = w_start_mode;
          w_i     = '0;
          w_t0    = WIDTH'(seed_t0(w_start_mode));
          w_t1    = '0;
          w_t2    = '0;
          w_sum   = WIDTH'(seed_t0(w_start_mode));
          w_done  = 1'b0;
          w_ov    = 1'b0;
        end
      end
      RUN: begin
        if (selector) begin
          w_i   = r_i + WIDTH'(1);
          w_t0  = w_term;
          w_t1  = r_t0;
          w_t2  = r_t1;
          w_sum = w_sum_add[WIDTH-1:0];
          w_ov  = r_ov | w_term_carry | w_sum_add[WIDTH];
          if (w_last) begin
            w_state = DONE;
            w_done  = 1'b1;
          end
        end
      end
      default: begin
        w_state = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_mode  <= FIB;
      r_i     <= '0;
      r_t0    <= '0;
      r_t1    <= '0;
      r_t2    <= '0;
      r_sum   <= '0;
      r_done  <= 1'b0;
      r_ov    <= 1'b0;
    end else begin
      r_state <= w_state;
      r_mode  <= w_mode;
      r_i     <= w_i;
      r_t0    <= w_t0;
      r_t1    <= w_t1;
      r_t2    <= w_t2;
      r_sum   <= w_sum;
      r_done  <= w_done;
      r_ov    <= w_ov;
    end
  end

  assign i           = r_i;
  assign n           = r_t0;
  assign sum         = r_sum;
  assign done        = r_done;
  assign overflow    = r_ov;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fib_seq_param.sv
// Directed bench for fib_seq_param (WIDTH=11, LIMIT=23) with a queue scoreboard.
module tb_fib_seq_param;
  import fib_seq_pkg::*;

  localparam int W   = 11;
  localparam int LIM = 23;
  localparam int EW  = 3 * W + 4;

  // ---------------- clock / reset / DUT ----------------
  logic         clk;
  logic         rst;
  logic         start;
  logic [1:0]   mode;
  logic         selector;
  logic [W-1:0] i;
  logic [W-1:0] n;
  logic [W-1:0] sum;
  logic         done;
  logic         overflow;
  state_e       dbg_state;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  fib_seq_param #(
    .WIDTH (W),
    .LIMIT (LIM)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .mode        (mode),
    .selector    (selector),
    .i           (i),
    .n           (n),
    .sum         (sum),
    .done        (done),
    .overflow    (overflow),
    .o_dbg_state (dbg_state)
  );

  // Hand-computed Fibonacci terms and running sums, modulo 2048.
  int fib_n [0:23] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 377,
                       610, 987, 1597, 536, 85, 621, 706, 1327, 2033};
  int fib_s [0:23] = '{0, 1, 2, 4, 7, 12, 20, 33, 54, 88, 143, 232, 376, 609,
                       986, 1596, 535, 84, 620, 705, 1326, 2032, 1311, 1296};
  int luc_n [0:4]  = '{1, 3, 4, 7, 11};
  int luc_s [0:4]  = '{3, 6, 10, 17, 28};
  int tri_n [0:5]  = '{0, 1, 1, 2, 4, 7};
  int tri_s [0:5]  = '{0, 1, 2, 4, 8, 15};
  int pel_n [0:3]  = '{1, 2, 5, 12};
  int pel_s [0:3]  = '{1, 3, 8, 20};

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  string         name_q[$];
  int            checks;
  int            failures;
  logic          end_req;
  logic          end_ack;

  // Drive one cycle of inputs and queue the outputs expected after that edge.
  task automatic cyc(input logic st, input logic [1:0] md, input logic sl,
                     input logic rs, input logic [W-1:0] ei,
                     input logic [W-1:0] en, input logic [W-1:0] es,
                     input logic ed, input logic eo, input state_e est,
                     input string nm);
    @(negedge clk);
    start    = st;
    mode     = md;
    selector = sl;
    rst      = rs;
    @(posedge clk);
    #1;
    exp_q.push_back({ei, en, es, ed, eo, est});
    name_q.push_back(nm);
  endtask

  task automatic rst_cyc(input string nm);
    cyc(1'b0, 2'b00, 1'b0, 1'b1, '0, '0, '0, 1'b0, 1'b0, IDLE, nm);
  endtask

  // Monitor: compare every queued expectation against the outputs it describes.
  initial begin
    logic [EW-1:0] e;
    logic [EW-1:0] act;
    string         nm;
    checks   = 0;
    failures = 0;
    end_ack  = 1'b0;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        nm  = name_q.pop_front();
        act = {i, n, sum, done, overflow, dbg_state};
        checks++;
        if (act !== e) begin
          failures++;
          $display("FAIL %s: got i=%0d n=%0d sum=%0d done=%0b ov=%0b st=%0d, want i=%0d n=%0d sum=%0d done=%0b ov=%0b st=%0d",
                   nm, i, n, sum, done, overflow, dbg_state,
                   e[EW-1 -: W], e[EW-1-W -: W], e[EW-1-2*W -: W],
                   e[3], e[2], e[1:0]);
        end
      end else if (end_req && !end_ack) begin
        checks++;
        if (name_q.size() != 0) begin
          failures++;
          $display("FAIL drain: got %0d leftover entries, want 0", name_q.size());
        end
        end_ack = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "time limit");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    mode     = 2'b00;
    selector = 1'b0;
    end_req  = 1'b0;

    // Reset, then IDLE holds even with selector high.
    rst_cyc("reset");
    cyc(1'b0, 2'b00, 1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0, IDLE, "idle_hold");
    cyc(1'b0, 2'b10, 1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0, IDLE, "idle_hold");

    // Fibonacci to LIMIT; start and selector both high in IDLE: start wins.
    cyc(1'b1, 2'b00, 1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0, RUN, "fib_start");
    for (int k = 1; k <= 23; k++) begin
      cyc(1'b0, 2'b00, 1'b1, 1'b0, W'(k), W'(fib_n[k]), W'(fib_s[k]),
          (k == 23), (k >= 16), (k == 23) ? DONE : RUN, "fib_adv");
    end
    // DONE freezes outputs with selector high and mode wiggling.
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, 2'(k), 1'b1, 1'b0, W'(23), W'(2033), W'(1296), 1'b1, 1'b1,
          DONE, "done_hold");
    end

    // Restart from DONE (overflow set) into Lucas; selector high too.
    cyc(1'b1, 2'b01, 1'b1, 1'b0, '0, W'(2), W'(2), 1'b0, 1'b0, RUN, "lucas_start");
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, 2'b00, 1'b1, 1'b0, W'(k + 1), W'(luc_n[k]), W'(luc_s[k]),
          1'b0, 1'b0, RUN, "lucas_adv");
    end

    // Tribonacci.
    rst_cyc("rst_after_lucas");
    cyc(1'b1, 2'b10, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, RUN, "trib_start");
    for (int k = 0; k < 6; k++) begin
      cyc(1'b0, 2'b01, 1'b1, 1'b0, W'(k + 1), W'(tri_n[k]), W'(tri_s[k]),
          1'b0, 1'b0, RUN, "trib_adv");
    end

    // Pell.
    rst_cyc("rst_after_trib");
    cyc(1'b1, 2'b11, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, RUN, "pell_start");
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 2'b00, 1'b1, 1'b0, W'(k + 1), W'(pel_n[k]), W'(pel_s[k]),
          1'b0, 1'b0, RUN, "pell_adv");
    end

    // Fibonacci with holds, mode changes and an ignored start in RUN.
    rst_cyc("rst_after_pell");
    cyc(1'b1, 2'b00, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, RUN, "fib2_start");
    for (int k = 1; k <= 7; k++) begin
      cyc(1'b0, 2'b00, 1'b1, 1'b0, W'(k), W'(fib_n[k]), W'(fib_s[k]),
          1'b0, 1'b0, RUN, "fib2_adv");
    end
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 2'(k), 1'b0, 1'b0, W'(7), W'(13), W'(33), 1'b0, 1'b0, RUN,
          "sel0_hold");
    end
    cyc(1'b1, 2'b11, 1'b0, 1'b0, W'(7), W'(13), W'(33), 1'b0, 1'b0, RUN,
        "start_in_run");
    for (int k = 8; k <= 12; k++) begin
      cyc(1'b0, 2'b01, 1'b1, 1'b0, W'(k), W'(fib_n[k]), W'(fib_s[k]),
          1'b0, 1'b0, RUN, "fib2_adv_after_hold");
    end

    // Reset mid-RUN with start and selector also high: reset wins.
    cyc(1'b1, 2'b01, 1'b1, 1'b1, '0, '0, '0, 1'b0, 1'b0, IDLE, "rst_priority");
    cyc(1'b1, 2'b00, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, RUN, "restart_after_rst");
    cyc(1'b0, 2'b00, 1'b1, 1'b0, W'(1), W'(1), W'(1), 1'b0, 1'b0, RUN, "restart_adv");

    @(negedge clk);
    start    = 1'b0;
    selector = 1'b0;
    repeat (2) @(negedge clk);
    end_req = 1'b1;
    for (int k = 0; k < 20 && !end_ack; k++) @(posedge clk);
    if (!end_ack) begin
      $display("FAIL end: got no summary from monitor, want summary");
      $fatal(1, "monitor did not finish");
    end
  end

endmodule
